// File: rtl/uart_frame_parser.sv
// Drains a UART receive FIFO, parses SYNC/LEN/payload/CSUM frames and streams the
// payload out on a valid/ready port once the XOR checksum has verified.
module uart_frame_parser #(
  parameter int                     N_DATA_BITS = 8,
  parameter int                     MAX_LEN     = 16,
  parameter logic [N_DATA_BITS-1:0] SYNC_BYTE   = 8'hA5,
  parameter int                     N_TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_empty,
  input  logic [N_DATA_BITS-1:0] r_data,
  output logic                   rd_uart,
  input  logic [N_TIMEOUT-1:0]   timeout_value,
  output logic [N_DATA_BITS-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [1:0]             err_code
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  state_t                 state_r;
  logic                   rd_uart_r;
  logic                   fetch_pend_r;
  logic [IDX_W-1:0]       len_r;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       rd_ptr_r;
  logic [N_DATA_BITS-1:0] csum_r;
  logic [N_TIMEOUT-1:0]   tmo_r;
  logic [N_DATA_BITS-1:0] m_data_r;
  logic                   m_valid_r;
  logic                   m_last_r;
  logic                   frame_err_r;
  logic [1:0]             err_code_r;
  logic [N_DATA_BITS-1:0] pay_mem_r [MAX_LEN];

  logic                   accept_s;
  logic                   timed_s;
  logic                   timeout_hit_s;
  logic                   handshake_s;
  logic [IDX_W-1:0]       idx_nxt_s;
  logic [IDX_W-1:0]       rd_nxt_s;
  logic [N_TIMEOUT-1:0]   tmo_inc_s;
  logic                   len_bad_s;

  // r_data holds the fetched byte during the cycle after the rd_uart pulse
  assign accept_s      = fetch_pend_r;
  assign timed_s       = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
  assign tmo_inc_s     = tmo_r + {{(N_TIMEOUT-1){1'b0}}, 1'b1};
  assign timeout_hit_s = timed_s && !accept_s && (timeout_value != {N_TIMEOUT{1'b0}})
                         && (tmo_inc_s == timeout_value);
  assign handshake_s   = m_valid_r && m_ready;
  assign idx_nxt_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign rd_nxt_s      = rd_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign len_bad_s     = (r_data == {N_DATA_BITS{1'b0}}) || (r_data > N_DATA_BITS'(MAX_LEN));

  assign rd_uart    = rd_uart_r;
  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign frame_err  = frame_err_r;
  assign err_code   = err_code_r;
  // Completion is reported in the very cycle the final beat is taken
  assign frame_done = handshake_s && m_last_r;

  // Payload buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (state_r == ST_PAYLOAD && accept_s) begin
      pay_mem_r[idx_r[ADDR_W-1:0]] <= r_data;
    end
  end

  // Frame FSM: fetch pacing, parsing, timeout and payload emission
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_HUNT;
      rd_uart_r    <= 1'b0;
      fetch_pend_r <= 1'b0;
      len_r        <= {IDX_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      rd_ptr_r     <= {IDX_W{1'b0}};
      csum_r       <= {N_DATA_BITS{1'b0}};
      tmo_r        <= {N_TIMEOUT{1'b0}};
      m_data_r     <= {N_DATA_BITS{1'b0}};
      m_valid_r    <= 1'b0;
      m_last_r     <= 1'b0;
      frame_err_r  <= 1'b0;
      err_code_r   <= 2'd0;
    end else begin
      // No new fetch while one is in flight, so a state change on accept never races a read
      rd_uart_r    <= (state_r != ST_EMIT) && !rx_empty && !rd_uart_r && !fetch_pend_r;
      fetch_pend_r <= rd_uart_r;
      frame_err_r  <= 1'b0;

      if (accept_s) begin
        tmo_r <= {N_TIMEOUT{1'b0}};
      end else if (timed_s) begin
        tmo_r <= tmo_inc_s;
      end

      if (timeout_hit_s) begin
        frame_err_r <= 1'b1;
        err_code_r  <= 2'd3;
        state_r     <= ST_HUNT;
      end else begin
        case (state_r)
          ST_HUNT: begin
            if (accept_s && r_data == SYNC_BYTE) begin
              state_r <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (accept_s) begin
              len_r  <= IDX_W'(r_data);
              csum_r <= r_data;
              idx_r  <= {IDX_W{1'b0}};
              if (len_bad_s) begin
                frame_err_r <= 1'b1;
                err_code_r  <= 2'd1;
                state_r     <= ST_HUNT;
              end else begin
                state_r <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (accept_s) begin
              csum_r <= csum_r ^ r_data;
              idx_r  <= idx_nxt_s;
              if (idx_nxt_s == len_r) begin
                state_r <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (accept_s) begin
              if (r_data == csum_r) begin
                rd_ptr_r  <= {IDX_W{1'b0}};
                m_data_r  <= pay_mem_r[{ADDR_W{1'b0}}];
                m_last_r  <= (len_r == {{(IDX_W-1){1'b0}}, 1'b1});
                m_valid_r <= 1'b1;
                state_r   <= ST_EMIT;
              end else begin
                frame_err_r <= 1'b1;
                err_code_r  <= 2'd2;
                state_r     <= ST_HUNT;
              end
            end
          end
          ST_EMIT: begin
            if (handshake_s) begin
              if (m_last_r) begin
                m_valid_r  <= 1'b0;
                m_last_r   <= 1'b0;
                err_code_r <= 2'd0;
                state_r    <= ST_HUNT;
              end else begin
                rd_ptr_r <= rd_nxt_s;
                m_data_r <= pay_mem_r[rd_nxt_s[ADDR_W-1:0]];
                m_last_r <= (rd_nxt_s == (len_r - {{(IDX_W-1){1'b0}}, 1'b1}));
              end
            end
          end
          default: begin
            state_r   <= ST_HUNT;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: FIFO model, table-driven frames with a
// beat/error scoreboard, plus timeout and asynchronous-reset sequences.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart;
  logic [15:0] timeout_value = 16'd20;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [63:0] bytes; int n; int off; bit good; logic [1:0] code; bit tog; } vec_t;

  beat_t      exp_q[$];
  logic [1:0] exp_err_q[$];
  logic [7:0] fifo_q[$];
  vec_t       vecs [6];

  int checks = 0, errors = 0;
  int rd_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0, last_acc = 0, last_err_edge = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;

  uart_frame_parser dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .timeout_value(timeout_value), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] vbyte(input logic [63:0] w, input int k);
    return w[63-8*k -: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    beat_t bt;
    bt.d = d;
    bt.l = l;
    exp_q.push_back(bt);
  endtask

  task automatic wait_idle(input bit tog, input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 600 && !idle; k++) begin
      tick();
      if (tog) m_ready = ~m_ready;
      idle = (fifo_q.size() == 0) && (exp_q.size() == 0) && (exp_err_q.size() == 0)
             && !m_valid && !rd_uart;
    end
    check({"idle_", tag}, {31'd0, idle}, 32'd1);
    m_ready = 1'b1;
    repeat (4) tick();
  endtask

  // FIFO model: the byte appears on r_data the cycle after the read pulse
  always @(posedge clk) begin
    cyc++;
    if (rd_uart && fifo_q.size() > 0) begin
      r_data <= fifo_q.pop_front();
      if (fifo_q.size() == 0) rx_empty <= 1'b1;
    end
  end

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (rd_uart) begin
        rd_cnt++;
        last_acc = cyc + 2;
        check("rd_not_empty", {31'd0, fifo_q.size() > 0}, 32'd1);
        check("rd_in_emit", {31'd0, m_valid}, 32'd0);
      end
      check("spurious_done", {31'd0, frame_done & ~(m_valid & m_ready & m_last)}, 32'd0);
      if (frame_err) begin
        err_cnt++;
        last_err_edge = cyc;
        check("err_done_excl", {31'd0, frame_done}, 32'd0);
        check("err_expected", {31'd0, exp_err_q.size() != 0}, 32'd1);
        if (exp_err_q.size() != 0) check("err_code", {30'd0, err_code}, {30'd0, exp_err_q.pop_front()});
      end
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          beat_t bt;
          bt = exp_q.pop_front();
          check("m_data", {24'd0, m_data}, {24'd0, bt.d});
          check("m_last", {31'd0, m_last}, {31'd0, bt.l});
          check("frame_done", {31'd0, frame_done}, {31'd0, bt.l});
        end
        if (frame_done) done_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int rd0, d0, e0, off, len;
    logic [63:0] w;

    vecs[0] = '{64'hA503112233030000, 6, 0, 1'b1, 2'd0, 1'b0};
    vecs[1] = '{64'h00FFA5015A5B0000, 6, 2, 1'b1, 2'd0, 1'b0};
    vecs[2] = '{64'hA502102000000000, 5, 0, 1'b0, 2'd2, 1'b0};
    vecs[3] = '{64'hA500000000000000, 2, 0, 1'b0, 2'd1, 1'b0};
    vecs[4] = '{64'hA511000000000000, 2, 0, 1'b0, 2'd1, 1'b0};
    vecs[5] = '{64'hA502AABB13000000, 5, 0, 1'b1, 2'd0, 1'b1};

    #12;
    check("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      rd0 = rd_cnt;
      d0  = done_cnt;
      w   = vecs[i].bytes;
      off = vecs[i].off;
      if (vecs[i].good) begin
        len = int'(vbyte(w, off + 1));
        for (int k = 0; k < len; k++) expect_beat(vbyte(w, off + 2 + k), k == len - 1);
      end else begin
        exp_err_q.push_back(vecs[i].code);
      end
      for (int k = 0; k < vecs[i].n; k++) push_byte(vbyte(w, k));
      wait_idle(vecs[i].tog, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_rd_count", i), rd_cnt - rd0, vecs[i].n);
      check($sformatf("vec%0d_err_code", i), {30'd0, err_code}, {30'd0, vecs[i].code});
      check($sformatf("vec%0d_done_count", i), done_cnt - d0, vecs[i].good ? 1 : 0);
    end

    // Inter-byte timeout: stall after the first payload byte
    timeout_value = 16'd20;
    exp_err_q.push_back(2'd3);
    push_byte(8'hA5); push_byte(8'h02); push_byte(8'hAA);
    wait_idle(1'b0, "timeout");
    check("timeout_latency", last_err_edge - last_acc, 32'd20);
    check("timeout_code", {30'd0, err_code}, 32'd3);
    d0 = done_cnt;
    expect_beat(8'h07, 1'b1);
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h07); push_byte(8'h06);
    wait_idle(1'b0, "after_timeout");
    check("after_timeout_done", done_cnt - d0, 32'd1);
    check("after_timeout_code", {30'd0, err_code}, 32'd0);

    // Timeout disabled: the same stall never errors, and the frame completes later
    timeout_value = 16'd0;
    e0 = err_cnt;
    d0 = done_cnt;
    push_byte(8'hA5); push_byte(8'h02); push_byte(8'hAA);
    repeat (300) tick();
    check("no_timeout_err", err_cnt - e0, 32'd0);
    check("no_timeout_valid", {31'd0, m_valid}, 32'd0);
    expect_beat(8'hAA, 1'b0);
    expect_beat(8'hBB, 1'b1);
    push_byte(8'hBB); push_byte(8'h13);
    wait_idle(1'b0, "no_timeout");
    check("no_timeout_done", done_cnt - d0, 32'd1);

    // Asynchronous reset while a beat is being presented
    timeout_value = 16'd20;
    exp_err_q.push_back(2'd2);
    push_byte(8'hA5); push_byte(8'h02); push_byte(8'h10); push_byte(8'h20); push_byte(8'h00);
    wait_idle(1'b0, "pre_reset_err");
    m_ready = 1'b0;
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h5A); push_byte(8'h5B);
    for (int k = 0; k < 100 && !m_valid; k++) tick();
    check("emit_reached", {31'd0, m_valid}, 32'd1);
    check("emit_err_held", {30'd0, err_code}, 32'd2);
    m_ready = 1'b1;
    #1;
    check("emit_done_comb", {31'd0, frame_done}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_m_valid", {31'd0, m_valid}, 32'd0);
    check("arst_frame_done", {31'd0, frame_done}, 32'd0);
    check("arst_err_code", {30'd0, err_code}, 32'd0);
    check("arst_m_last", {31'd0, m_last}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();
    d0 = done_cnt;
    expect_beat(8'h07, 1'b1);
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h07); push_byte(8'h06);
    wait_idle(1'b0, "post_reset");
    check("post_reset_done", done_cnt - d0, 32'd1);
    check("post_reset_code", {30'd0, err_code}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
